// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan controller with frame-synchronous double-buffered display data
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    lzb_en,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic [3:0]              digit_code,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);
    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [4*NUM_DIGITS-1:0] active, shadow, active_nx;
    logic [NUM_DIGITS-1:0]   active_dp, shadow_dp, active_dp_nx;
    logic                    wrap, accept, lead_zero, suppress, lit;
    logic [3:0]              code_nx;

    // next scan position, frame-boundary commit, and the view of the slot about to be driven
    always_comb begin
        state_nx = state;
        cnt_nx = cnt + 1'b1;
        idx_nx = idx;
        wrap = 1'b0;
        if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nx = SHOW;
                cnt_nx = '0;
            end
        end else if (cnt == SHOW_LAST) begin
            state_nx = (BLANK_CYCLES == 0) ? SHOW : BLANK;
            cnt_nx = '0;
            wrap = (idx == IDX_LAST);
            idx_nx = wrap ? '0 : idx + 1'b1;
        end
        accept = load_valid && load_ready;
        active_nx = (wrap && !load_ready) ? shadow : active;
        active_dp_nx = (wrap && !load_ready) ? shadow_dp : active_dp;
        code_nx = active_nx[4*idx_nx +: 4];
        lead_zero = lzb_en && (idx_nx != '0);
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(idx_nx) && (active_nx[4*i +: 4] != 4'd0 || active_dp_nx[i]))
                lead_zero = 1'b0;
        suppress = !enable || (code_nx > 4'd9) || lead_zero;
        lit = (state_nx == SHOW) && !suppress;
    end

    // scan FSM, handshake, data buffers and registered display outputs, all updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt <= '0;
            idx <= '0;
            active <= '0;
            active_dp <= '0;
            shadow <= '0;
            shadow_dp <= '0;
            load_ready <= 1'b1;
            an_n <= '1;
            digit_code <= 4'd0;
            dp_n <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            idx <= idx_nx;
            active <= active_nx;
            active_dp <= active_dp_nx;
            if (accept) begin
                shadow <= load_data;
                shadow_dp <= load_dp;
            end
            load_ready <= accept ? 1'b0 : (wrap ? 1'b1 : load_ready);
            an_n <= lit ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
            digit_code <= code_nx;
            dp_n <= !(lit && active_dp_nx[idx_nx]);
            frame_done <= wrap;
        end
    end
endmodule
